// File: rtl/avalon_rr_arbiter.sv
// avalon_rr_arbiter: two-master round-robin Avalon-MM arbiter with tag FIFO routing read returns
module avalon_rr_arbiter #(
  parameter int ADDR = 32,
  parameter int TAG_DEPTH = 4
) (
  input  logic            clk_sys,
  input  logic            rst,
  input  logic [ADDR-1:0] m0_addr,
  input  logic            m0_write,
  input  logic [31:0]     m0_writedata,
  input  logic            m0_read,
  input  logic [3:0]      m0_byteenable,
  output logic            m0_waitrequest,
  output logic [31:0]     m0_readdata,
  output logic            m0_readdatavalid,
  input  logic [ADDR-1:0] m1_addr,
  input  logic            m1_write,
  input  logic [31:0]     m1_writedata,
  input  logic            m1_read,
  input  logic [3:0]      m1_byteenable,
  output logic            m1_waitrequest,
  output logic [31:0]     m1_readdata,
  output logic            m1_readdatavalid,
  output logic [ADDR-1:0] s_addr,
  output logic            s_write,
  output logic [31:0]     s_writedata,
  output logic            s_read,
  output logic [3:0]      s_byteenable,
  input  logic            s_waitrequest,
  input  logic [31:0]     s_readdata,
  input  logic            s_readdatavalid
);
  localparam int PW = $clog2(TAG_DEPTH);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  state_t state_q, state_d;
  logic last_q, last_d;
  logic [PW:0] tag_count_q, tag_count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [TAG_DEPTH-1:0] tags_q, tags_d;
  logic [1:0] req;
  logic gnt, sel, sel_read, sel_write, full, read_blocked, accept, push, pop, head;
  always_comb begin
    req = {m1_read | m1_write, m0_read | m0_write};
    gnt = state_q != IDLE;
    sel = state_q == GNT1;
    sel_read = gnt & (sel ? m1_read : m0_read);
    sel_write = gnt & (sel ? m1_write : m0_write);
    full = tag_count_q == (PW+1)'(TAG_DEPTH);
    read_blocked = sel_read & full;
    s_read = sel_read & !full;
    s_write = sel_write;
    s_addr = !gnt ? '0 : sel ? m1_addr : m0_addr;
    s_writedata = !gnt ? '0 : sel ? m1_writedata : m0_writedata;
    s_byteenable = !gnt ? '0 : sel ? m1_byteenable : m0_byteenable;
    m0_waitrequest = state_q == GNT0 ? s_waitrequest | read_blocked : 1'b1;
    m1_waitrequest = state_q == GNT1 ? s_waitrequest | read_blocked : 1'b1;
    accept = (s_read | s_write) & !s_waitrequest;
    push = accept & s_read;
    pop = s_readdatavalid & (tag_count_q != '0);
    head = tags_q[rd_ptr_q];
    m0_readdatavalid = pop & !head;
    m1_readdatavalid = pop & head;
    m0_readdata = s_readdata;
    m1_readdata = s_readdata;
    state_d = !gnt ? (req == 2'b11 ? (last_q ? GNT0 : GNT1) : req[0] ? GNT0 : req[1] ? GNT1 : IDLE)
                   : (accept | !req[sel]) ? IDLE : state_q;
    last_d = accept ? sel : last_q;
    tags_d = tags_q;
    tags_d[wr_ptr_q] = push ? sel : tags_q[wr_ptr_q];
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    tag_count_d = tag_count_q + (PW+1)'(push) - (PW+1)'(pop);
  end
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      tag_count_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      tags_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      tag_count_q <= tag_count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      tags_q <= tags_d;
    end
  end
endmodule

// File: tb/tb_avalon_rr_arbiter.sv
// tb_avalon_rr_arbiter: vector table, corner sequences and randomized model check of avalon_rr_arbiter
module tb_avalon_rr_arbiter;
  localparam int DEPTH = 4;
  logic clk_sys = 1'b0, rst = 1'b1;
  logic [31:0] m0_addr, m0_writedata, m0_readdata, m1_addr, m1_writedata, m1_readdata;
  logic m0_write, m0_read, m0_waitrequest, m0_readdatavalid;
  logic m1_write, m1_read, m1_waitrequest, m1_readdatavalid;
  logic [3:0] m0_byteenable, m1_byteenable, s_byteenable;
  logic [31:0] s_addr, s_writedata, s_readdata;
  logic s_write, s_read, s_waitrequest, s_readdatavalid;
  int total = 0, passed = 0;
  typedef struct packed {
    logic m0r, m0w, m1r, m1w, sw, rdv;
    logic srd, swr;
    logic [31:0] sa;
    logic w0, w1, v0, v1;
  } vec_t;
  vec_t tbl [19];
  avalon_rr_arbiter #(.ADDR(32), .TAG_DEPTH(DEPTH)) dut (
    .clk_sys(clk_sys), .rst(rst),
    .m0_addr(m0_addr), .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_read(m0_read),
    .m0_byteenable(m0_byteenable), .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_addr(m1_addr), .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_read(m1_read),
    .m1_byteenable(m1_byteenable), .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .s_addr(s_addr), .s_write(s_write), .s_writedata(s_writedata), .s_read(s_read),
    .s_byteenable(s_byteenable), .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid)
  );
  always #5 clk_sys = ~clk_sys;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  task automatic next();
    @(posedge clk_sys);
    #1;
  endtask
  task automatic idle_inputs();
    {m0_read, m0_write, m1_read, m1_write, s_waitrequest, s_readdatavalid} = '0;
    m0_addr = 32'h10; m0_writedata = 32'hA5A5A5A5; m0_byteenable = 4'hF;
    m1_addr = 32'h20; m1_writedata = 32'h5A5A5A5A; m1_byteenable = 4'h3;
    s_readdata = 32'h0;
  endtask
  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) next();
    rst = 1'b0;
  endtask
  int gm, gi, acc, nacc;
  bit mlast, pend;
  logic [31:0] pdata;
  int tq [$];
  int gq [$];
  logic [32:0] rq [$];
  bit rd [2], wr [2], e_w [2], e_v [2];
  logic [31:0] a [2], wd [2];
  logic [3:0] be [2];
  bit full, e_srd, e_swr, acpt, g;
  int k;
  initial begin
    tbl[0]  = '{0,0,0,0,0,0, 0,0,32'h00, 1,1,0,0};
    tbl[1]  = '{0,1,0,0,0,0, 0,0,32'h00, 1,1,0,0};
    tbl[2]  = '{0,1,0,0,0,0, 0,1,32'h10, 0,1,0,0};
    tbl[3]  = '{0,0,0,0,0,0, 0,0,32'h00, 1,1,0,0};
    tbl[4]  = '{1,0,1,0,0,0, 0,0,32'h00, 1,1,0,0};
    tbl[5]  = '{1,0,1,0,0,0, 1,0,32'h20, 1,0,0,0};
    tbl[6]  = '{1,0,0,0,0,1, 0,0,32'h00, 1,1,0,1};
    tbl[7]  = '{1,0,0,0,0,0, 1,0,32'h10, 0,1,0,0};
    tbl[8]  = '{0,0,0,0,0,1, 0,0,32'h00, 1,1,1,0};
    tbl[9]  = '{0,0,0,0,0,1, 0,0,32'h00, 1,1,0,0};
    tbl[10] = '{0,0,0,1,1,0, 0,0,32'h00, 1,1,0,0};
    tbl[11] = '{0,0,0,1,1,0, 0,1,32'h20, 1,1,0,0};
    tbl[12] = '{0,0,0,1,0,0, 0,1,32'h20, 1,0,0,0};
    tbl[13] = '{0,1,0,0,0,0, 0,0,32'h00, 1,1,0,0};
    tbl[14] = '{0,1,0,0,1,0, 0,1,32'h10, 1,1,0,0};
    tbl[15] = '{0,0,0,0,0,0, 0,0,32'h10, 0,1,0,0};
    tbl[16] = '{1,0,1,0,0,0, 0,0,32'h00, 1,1,0,0};
    tbl[17] = '{1,0,1,0,0,0, 1,0,32'h10, 0,1,0,0};
    tbl[18] = '{0,0,0,0,0,1, 0,0,32'h00, 1,1,1,0};
    do_reset();
    for (int i = 0; i < 19; i++) begin
      {m0_read, m0_write, m1_read, m1_write, s_waitrequest, s_readdatavalid} =
        {tbl[i].m0r, tbl[i].m0w, tbl[i].m1r, tbl[i].m1w, tbl[i].sw, tbl[i].rdv};
      s_readdata = 32'hD000_0000 + i;
      #2;
      chk($sformatf("t%0d s_read", i), s_read, tbl[i].srd);
      chk($sformatf("t%0d s_write", i), s_write, tbl[i].swr);
      chk($sformatf("t%0d s_addr", i), s_addr, tbl[i].sa);
      chk($sformatf("t%0d m0_waitrequest", i), m0_waitrequest, tbl[i].w0);
      chk($sformatf("t%0d m1_waitrequest", i), m1_waitrequest, tbl[i].w1);
      chk($sformatf("t%0d m0_readdatavalid", i), m0_readdatavalid, tbl[i].v0);
      chk($sformatf("t%0d m1_readdatavalid", i), m1_readdatavalid, tbl[i].v1);
      if (i == 0) chk("reset s_writedata", s_writedata, 32'h0);
      if (i == 0) chk("reset s_byteenable", s_byteenable, 4'h0);
      if (i == 2) chk("write s_writedata", s_writedata, 32'hA5A5A5A5);
      if (i == 8) chk("m0_readdata", m0_readdata, 32'hD000_0008);
      next();
    end
    do_reset();
    m0_read = 1'b1; m1_read = 1'b1; pend = 1'b0; nacc = 0;
    for (int c = 0; c < 12; c++) begin
      s_readdatavalid = pend; s_readdata = pdata; pend = 1'b0;
      #2;
      if (m0_readdatavalid) rq.push_back({1'b0, m0_readdata});
      if (m1_readdatavalid) rq.push_back({1'b1, m1_readdata});
      if (s_read && !s_waitrequest) begin
        gq.push_back(!m0_waitrequest ? 0 : 1);
        nacc++; pend = 1'b1; pdata = 32'h11 * nacc;
      end
      next();
    end
    chk("contention grants", gq.size() >= 4, 1);
    chk("contention returns", rq.size() >= 4, 1);
    for (int i = 0; i < 4; i++) begin
      if (i < gq.size()) chk($sformatf("contention grant%0d", i), gq[i], i % 2);
      if (i < rq.size()) chk($sformatf("contention rdv%0d", i), rq[i], {i[0], 32'h11 * (i + 1)});
    end
    do_reset();
    m1_read = 1'b1; m1_addr = 32'h30; acc = 0;
    for (int c = 0; c < 20 && acc < 4; c++) begin
      #2;
      if (s_read && !s_waitrequest) acc++;
      next();
    end
    chk("tagfull accepts", acc, 4);
    for (int c = 0; c < 3; c++) begin
      #2;
      chk($sformatf("tagfull%0d s_read", c), s_read, 1'b0);
      chk($sformatf("tagfull%0d m1_waitrequest", c), m1_waitrequest, 1'b1);
      next();
    end
    s_readdatavalid = 1'b1;
    #2;
    chk("popcycle m1_readdatavalid", m1_readdatavalid, 1'b1);
    chk("popcycle s_read", s_read, 1'b0);
    chk("popcycle m1_waitrequest", m1_waitrequest, 1'b1);
    next();
    s_readdatavalid = 1'b0;
    #2;
    chk("afterpop s_read", s_read, 1'b1);
    chk("afterpop m1_waitrequest", m1_waitrequest, 1'b0);
    next();
    do_reset();
    m0_write = 1'b1; m1_write = 1'b1; s_waitrequest = 1'b1;
    m0_addr = 32'h44; m0_writedata = 32'h12345678; m0_byteenable = 4'h3;
    next();
    for (int c = 0; c < 4; c++) begin
      s_waitrequest = c < 3;
      #2;
      chk($sformatf("stall%0d s_write", c), s_write, 1'b1);
      chk($sformatf("stall%0d s_addr", c), s_addr, 32'h44);
      chk($sformatf("stall%0d s_writedata", c), s_writedata, 32'h12345678);
      chk($sformatf("stall%0d s_byteenable", c), s_byteenable, 4'h3);
      chk($sformatf("stall%0d m1_waitrequest", c), m1_waitrequest, 1'b1);
      next();
    end
    m0_write = 1'b0;
    #2;
    chk("stall idle s_write", s_write, 1'b0);
    next();
    #2;
    chk("stall m1 s_addr", s_addr, 32'h20);
    chk("stall m1 waitrequest", m1_waitrequest, 1'b0);
    next();
    do_reset();
    m0_read = 1'b1; acc = 0;
    for (int c = 0; c < 10 && acc < 2; c++) begin
      #2;
      if (s_read && !s_waitrequest) acc++;
      next();
    end
    chk("pre-reset reads", acc, 2);
    m0_read = 1'b0; rst = 1'b1;
    next();
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      s_readdatavalid = 1'b1;
      #2;
      chk($sformatf("stale%0d m0_readdatavalid", c), m0_readdatavalid, 1'b0);
      chk($sformatf("stale%0d m1_readdatavalid", c), m1_readdatavalid, 1'b0);
      next();
    end
    s_readdatavalid = 1'b0;
    #2;
    chk("post-reset tag_count", dut.tag_count_q, 0);
    chk("post-reset m0_waitrequest", m0_waitrequest, 1'b1);
    m0_read = 1'b1; acc = 0;
    for (int c = 0; c < 6 && acc < 1; c++) begin
      #2;
      if (s_read && !s_waitrequest) acc++;
      next();
    end
    chk("post-reset read accepted", acc, 1);
    m0_read = 1'b0; s_readdatavalid = 1'b1; s_readdata = 32'hCAFEF00D;
    #2;
    chk("post-reset m0_readdatavalid", m0_readdatavalid, 1'b1);
    chk("post-reset m1_readdatavalid", m1_readdatavalid, 1'b0);
    chk("post-reset m0_readdata", m0_readdata, 32'hCAFEF00D);
    next();
    do_reset();
    gm = -1; mlast = 1'b1; tq.delete();
    for (int c = 0; c < 400; c++) begin
      for (int n = 0; n < 2; n++) begin
        k = $urandom_range(0, 5);
        rd[n] = k == 1 || k == 2 || k == 3;
        wr[n] = k == 4;
        a[n] = $urandom; wd[n] = $urandom; be[n] = 4'($urandom_range(0, 15));
      end
      {m0_read, m0_write, m0_addr, m0_writedata, m0_byteenable} = {rd[0], wr[0], a[0], wd[0], be[0]};
      {m1_read, m1_write, m1_addr, m1_writedata, m1_byteenable} = {rd[1], wr[1], a[1], wd[1], be[1]};
      s_waitrequest = $urandom_range(0, 3) == 0;
      s_readdatavalid = $urandom_range(0, 9) < ((c % 100) < 50 ? 1 : 5);
      s_readdata = $urandom;
      g = gm >= 0; gi = g ? gm : 0;
      full = tq.size() == DEPTH;
      e_srd = g && rd[gi] && !full;
      e_swr = g && wr[gi];
      for (int n = 0; n < 2; n++) begin
        e_w[n] = g && gm == n ? (s_waitrequest || (rd[n] && full)) : 1'b1;
        e_v[n] = s_readdatavalid && tq.size() > 0 && tq[0] == n;
      end
      #2;
      chk($sformatf("rnd%0d s_read", c), s_read, e_srd);
      chk($sformatf("rnd%0d s_write", c), s_write, e_swr);
      chk($sformatf("rnd%0d s_addr", c), s_addr, g ? a[gi] : 32'h0);
      chk($sformatf("rnd%0d s_writedata", c), s_writedata, g ? wd[gi] : 32'h0);
      chk($sformatf("rnd%0d s_byteenable", c), s_byteenable, g ? be[gi] : 4'h0);
      chk($sformatf("rnd%0d m0_waitrequest", c), m0_waitrequest, e_w[0]);
      chk($sformatf("rnd%0d m1_waitrequest", c), m1_waitrequest, e_w[1]);
      chk($sformatf("rnd%0d m0_readdatavalid", c), m0_readdatavalid, e_v[0]);
      chk($sformatf("rnd%0d m1_readdatavalid", c), m1_readdatavalid, e_v[1]);
      acpt = (e_srd || e_swr) && !s_waitrequest;
      if (s_readdatavalid && tq.size() > 0) void'(tq.pop_front());
      if (acpt && e_srd) tq.push_back(gm);
      if (!g) begin
        if ((rd[0] || wr[0]) && (rd[1] || wr[1])) gm = mlast ? 0 : 1;
        else if (rd[0] || wr[0]) gm = 0;
        else if (rd[1] || wr[1]) gm = 1;
      end else if (acpt) begin
        mlast = gm[0]; gm = -1;
      end else if (!(rd[gi] || wr[gi])) gm = -1;
      next();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
